// File: rtl/sync_arb_pkg.sv
// Shared types and constants for the synchronizer channel arbiter.
//   sync_arb_state_t : arbiter FSM states
//   SYNC_STAGES      : depth of the shared synchronizer shift register
//   MIN_TIMEOUT      : smallest legal TIMEOUT_CYCLES
package sync_arb_pkg;

   localparam int unsigned SYNC_STAGES = 3;
   localparam int unsigned MIN_TIMEOUT = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      DRAIN  = 2'd3
   } sync_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index the search starts from (wraps modulo NUM_REQ)
//   grant : one-hot winner, all-zero when req is zero
//   idx   : encoded winner index, 0 when req is zero
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   // Walk offsets from farthest to nearest so the requester closest to ptr is written last and wins.
   always_comb begin
      int unsigned cand;
      grant = '0;
      idx   = '0;
      cand  = 0;
      for (int unsigned n = 0; n < NUM_REQ; n++) begin
         cand = (32'(ptr) + (NUM_REQ - 1 - n)) % NUM_REQ;
         if (|(req & (NUM_REQ'(1) << cand))) begin
            grant = NUM_REQ'(1) << cand;
            idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/sync_chan_arb.sv
// Round-robin scheduler sharing one synchronizer shift register among NUM_REQ requesters.
//   clk, reset          : clock, asynchronous active-high reset
//   req_i, req_data_i   : level requests and flattened per-requester launch data
//   grant_o             : one-hot pulse when a request is accepted
//   done_o / err_o      : one-hot pulse on completion / timeout of the owner's transfer
//   rdata_o             : last captured synchronizer output, rdata_owner_o its owner
//   busy_o              : arbiter not idle
//   sr_enable_o, sr_d_o : synchronizer launch handshake and data
//   sr_enable_ack_i, sr_valid_i, sr_q_i : synchronizer acknowledge, valid and output data
module sync_chan_arb
   import sync_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_BIT_WIDTH = 3,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_REQ-1:0]                 req_i,
   input  logic [NUM_REQ*DATA_BIT_WIDTH-1:0]  req_data_i,
   output logic [NUM_REQ-1:0]                 grant_o,
   output logic [NUM_REQ-1:0]                 done_o,
   output logic [NUM_REQ-1:0]                 err_o,
   output logic [DATA_BIT_WIDTH-1:0]          rdata_o,
   output logic [$clog2(NUM_REQ)-1:0]         rdata_owner_o,
   output logic                               busy_o,
   output logic                               sr_enable_o,
   output logic [DATA_BIT_WIDTH-1:0]          sr_d_o,
   input  logic                               sr_enable_ack_i,
   input  logic                               sr_valid_i,
   input  logic [DATA_BIT_WIDTH-1:0]          sr_q_i
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   if (NUM_REQ < 2 || DATA_BIT_WIDTH <= 1 || TIMEOUT_CYCLES < MIN_TIMEOUT) begin : g_param_check
      $error("sync_chan_arb: illegal NUM_REQ, DATA_BIT_WIDTH or TIMEOUT_CYCLES");
   end

   sync_arb_state_t           state;
   logic [IDX_W-1:0]          ptr;
   logic [IDX_W-1:0]          owner;
   logic [CNT_W-1:0]          tmo_cnt;

   logic [NUM_REQ-1:0]        arb_grant;
   logic [IDX_W-1:0]          arb_idx;
   logic [DATA_BIT_WIDTH-1:0] arb_data;
   logic [IDX_W-1:0]          ptr_next;
   logic [NUM_REQ-1:0]        owner_onehot;
   logic [CNT_W-1:0]          tmo_cnt_inc;
   logic                      timeout_hit;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req   (req_i),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx)
   );

   assign arb_data     = DATA_BIT_WIDTH'(req_data_i >> (32'(arb_idx) * DATA_BIT_WIDTH));
   assign ptr_next     = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
   assign owner_onehot = NUM_REQ'(1) << owner;

   // Counter is cleared at grant, so it reads TIMEOUT_CYCLES-1 during the last allowed cycle.
   assign timeout_hit  = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign tmo_cnt_inc  = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES)) ? tmo_cnt : tmo_cnt + CNT_W'(1);

   // Arbiter FSM with registered outputs; pulses default low every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         ptr           <= '0;
         owner         <= '0;
         tmo_cnt       <= '0;
         grant_o       <= '0;
         done_o        <= '0;
         err_o         <= '0;
         rdata_o       <= '0;
         rdata_owner_o <= '0;
         busy_o        <= 1'b0;
         sr_enable_o   <= 1'b0;
         sr_d_o        <= '0;
      end else begin
         grant_o <= '0;
         done_o  <= '0;
         err_o   <= '0;
         case (state)
            IDLE: begin
               if (|req_i) begin
                  grant_o     <= arb_grant;
                  owner       <= arb_idx;
                  sr_d_o      <= arb_data;
                  ptr         <= ptr_next;
                  tmo_cnt     <= '0;
                  sr_enable_o <= 1'b1;
                  busy_o      <= 1'b1;
                  state       <= LAUNCH;
               end
            end
            LAUNCH: begin
               tmo_cnt <= tmo_cnt_inc;
               if (timeout_hit) begin
                  err_o       <= owner_onehot;
                  sr_enable_o <= 1'b0;
                  state       <= DRAIN;
               end else if (sr_enable_ack_i) begin
                  sr_enable_o <= 1'b0;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               tmo_cnt <= tmo_cnt_inc;
               // Completion takes priority over a timeout expiring in the same cycle.
               if (sr_valid_i) begin
                  rdata_o       <= sr_q_i;
                  rdata_owner_o <= owner;
                  done_o        <= owner_onehot;
                  state         <= DRAIN;
               end else if (timeout_hit) begin
                  err_o       <= owner_onehot;
                  sr_enable_o <= 1'b0;
                  state       <= DRAIN;
               end
            end
            DRAIN: begin
               // Let a multi-cycle valid finish before accepting the next request.
               if (!sr_valid_i) begin
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sync_chan_arb.sv
// Self-checking bench for sync_chan_arb: table-driven transfers plus hand-written corner sequences,
// with completions and timeouts matched against a scoreboard queue.
module tb_sync_chan_arb;
   import sync_arb_pkg::*;

   localparam int unsigned NR  = 4;
   localparam int unsigned DW  = 3;
   localparam int unsigned TMO = 16;

   logic             clk;
   logic             reset;
   logic [NR-1:0]    req_i;
   logic [NR*DW-1:0] req_data_i;
   logic [NR-1:0]    grant_o;
   logic [NR-1:0]    done_o;
   logic [NR-1:0]    err_o;
   logic [DW-1:0]    rdata_o;
   logic [1:0]       rdata_owner_o;
   logic             busy_o;
   logic             sr_enable_o;
   logic [DW-1:0]    sr_d_o;
   logic             sr_enable_ack_i;
   logic             sr_valid_i;
   logic [DW-1:0]    sr_q_i;

   // Synchronizer source select: behavioural model or hand-driven pins.
   logic             use_model;
   logic             man_ack;
   logic             man_valid;
   logic [DW-1:0]    man_q;
   logic             m_ack;
   logic [SYNC_STAGES-1:0] m_pipe;
   logic [DW-1:0]    m_data;

   typedef struct {
      bit            is_err;
      int            owner;
      logic [DW-1:0] rdata;
      int            lat;
   } exp_t;

   typedef struct {
      logic [NR-1:0]    req;
      logic [NR*DW-1:0] data;
      logic [NR-1:0]    exp_grant;
      int               exp_owner;
      logic [DW-1:0]    exp_rdata;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[8];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   last_grant = 0;

   sync_chan_arb #(
      .NUM_REQ        (NR),
      .DATA_BIT_WIDTH (DW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_i           (req_i),
      .req_data_i      (req_data_i),
      .grant_o         (grant_o),
      .done_o          (done_o),
      .err_o           (err_o),
      .rdata_o         (rdata_o),
      .rdata_owner_o   (rdata_owner_o),
      .busy_o          (busy_o),
      .sr_enable_o     (sr_enable_o),
      .sr_d_o          (sr_d_o),
      .sr_enable_ack_i (sr_enable_ack_i),
      .sr_valid_i      (sr_valid_i),
      .sr_q_i          (sr_q_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronizer model: ack one cycle after enable, valid two cycles long through the stage pipe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_ack  <= 1'b0;
         m_pipe <= '0;
         m_data <= '0;
      end else begin
         m_ack  <= sr_enable_o && !m_ack;
         m_pipe <= {m_pipe[SYNC_STAGES-2:0], sr_enable_o && m_ack};
         if (sr_enable_o && !m_ack) m_data <= sr_d_o;
      end
   end

   assign sr_enable_ack_i = use_model ? m_ack : man_ack;
   assign sr_valid_i      = use_model ? (m_pipe[SYNC_STAGES-2] | m_pipe[SYNC_STAGES-1]) : man_valid;
   assign sr_q_i          = use_model ? m_data : man_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_grant(input string name, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (grant_o != '0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL %s: no grant within 40 cycles", name);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy_o && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle_busy", 32'(busy_o), 0);
   endtask

   // Scoreboard monitor: every done/err pulse pops one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (grant_o != '0) last_grant = cyc;
         if (done_o != '0 || err_o != '0) begin
            if (sb.size() == 0) begin
               check("unexpected_done_err", {24'd0, done_o, err_o}, 0);
            end else begin
               e = sb.pop_front();
               if (e.is_err) begin
                  check("err_onehot", 32'(err_o), 32'(1) << e.owner);
                  check("err_no_done", 32'(done_o), 0);
                  check("err_latency", cyc - last_grant, e.lat);
               end else begin
                  check("done_onehot", 32'(done_o), 32'(1) << e.owner);
                  check("done_no_err", 32'(err_o), 0);
                  check("done_rdata", 32'(rdata_o), 32'(e.rdata));
                  check("done_owner", 32'(rdata_owner_o), e.owner);
                  check("done_latency", cyc - last_grant, e.lat);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int prev;
      int drive_cyc;

      // {d3,d2,d1,d0} slot layout; pointer enters the table at 1 after the all-request run.
      vecs[0] = '{req:4'b0010, data:{3'd0, 3'd0, 3'd5, 3'd0}, exp_grant:4'b0010, exp_owner:1, exp_rdata:3'd5};
      vecs[1] = '{req:4'b1111, data:{3'd1, 3'd2, 3'd3, 3'd4}, exp_grant:4'b0100, exp_owner:2, exp_rdata:3'd2};
      vecs[2] = '{req:4'b1111, data:{3'd6, 3'd7, 3'd1, 3'd3}, exp_grant:4'b1000, exp_owner:3, exp_rdata:3'd6};
      vecs[3] = '{req:4'b1001, data:{3'd5, 3'd0, 3'd0, 3'd2}, exp_grant:4'b0001, exp_owner:0, exp_rdata:3'd2};
      vecs[4] = '{req:4'b0110, data:{3'd0, 3'd4, 3'd7, 3'd0}, exp_grant:4'b0010, exp_owner:1, exp_rdata:3'd7};
      vecs[5] = '{req:4'b0001, data:{3'd0, 3'd0, 3'd0, 3'd6}, exp_grant:4'b0001, exp_owner:0, exp_rdata:3'd6};
      vecs[6] = '{req:4'b1000, data:{3'd3, 3'd0, 3'd0, 3'd0}, exp_grant:4'b1000, exp_owner:3, exp_rdata:3'd3};
      vecs[7] = '{req:4'b0100, data:{3'd0, 3'd1, 3'd0, 3'd0}, exp_grant:4'b0100, exp_owner:2, exp_rdata:3'd1};

      reset      = 1'b1;
      req_i      = '0;
      req_data_i = '0;
      use_model  = 1'b1;
      man_ack    = 1'b0;
      man_valid  = 1'b0;
      man_q      = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            32'({grant_o, done_o, err_o, rdata_o, rdata_owner_o, busy_o, sr_enable_o, sr_d_o}), 0);
      reset = 1'b0;
      @(negedge clk);

      // All requesters held high: 0,1,2,3,0 at 7-cycle spacing.
      req_data_i = {3'd4, 3'd3, 3'd2, 3'd1};
      req_i      = 4'b1111;
      prev       = 0;
      for (int g = 0; g < 5; g++) begin
         sb.push_back('{is_err:1'b0, owner:g % 4, rdata:DW'(g % 4 + 1), lat:4});
         wait_grant("all_req_grant", ok);
         check("all_req_grant_order", 32'(grant_o), 32'(1) << (g % 4));
         if (g > 0) check("all_req_spacing", cyc - prev, 7);
         prev = cyc;
      end
      req_i = '0;

      // Table of single transfers through the model synchronizer.
      for (int i = 0; i < 8; i++) begin
         wait_idle();
         req_i      = vecs[i].req;
         req_data_i = vecs[i].data;
         drive_cyc  = cyc;
         sb.push_back('{is_err:1'b0, owner:vecs[i].exp_owner, rdata:vecs[i].exp_rdata, lat:4});
         wait_grant($sformatf("vec%0d_grant", i), ok);
         req_i = '0;
         check($sformatf("vec%0d_grant", i), 32'(grant_o), 32'(vecs[i].exp_grant));
         check($sformatf("vec%0d_grant_lat", i), cyc - drive_cyc, 1);
         check($sformatf("vec%0d_enable", i), 32'(sr_enable_o), 1);
         check($sformatf("vec%0d_sr_d", i), 32'(sr_d_o), 32'(vecs[i].exp_rdata));
      end

      // Stuck synchronizer: no ack, timeout after TMO cycles, rdata untouched.
      wait_idle();
      use_model  = 1'b0;
      req_i      = 4'b0001;
      req_data_i = {3'd0, 3'd0, 3'd0, 3'b011};
      sb.push_back('{is_err:1'b1, owner:0, rdata:'0, lat:TMO});
      wait_grant("stuck_grant", ok);
      req_i = '0;
      check("stuck_grant", 32'(grant_o), 32'b0001);
      repeat (TMO - 1) @(negedge clk);
      check("stuck_enable_before_timeout", 32'(sr_enable_o), 1);
      @(negedge clk);
      check("stuck_enable_after_timeout", 32'(sr_enable_o), 0);
      check("stuck_rdata_kept", 32'(rdata_o), 32'd1);
      check("stuck_owner_kept", 32'(rdata_owner_o), 32'd2);

      // Valid arrives in the timeout cycle and lasts 3 cycles: one done, no err.
      wait_idle();
      req_i      = 4'b0001;
      req_data_i = {3'd0, 3'd0, 3'd0, 3'b110};
      sb.push_back('{is_err:1'b0, owner:0, rdata:3'b110, lat:TMO});
      wait_grant("race_grant", ok);
      req_i = '0;
      check("race_grant", 32'(grant_o), 32'b0001);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      repeat (TMO - 2) @(negedge clk);
      man_valid = 1'b1;
      man_q     = 3'b110;
      repeat (3) @(negedge clk);
      man_valid = 1'b0;
      man_q     = '0;

      // Reset while in WAIT, then regrant from pointer 0 with the request still held.
      wait_idle();
      use_model  = 1'b1;
      req_data_i = {3'b010, 3'd0, 3'b100, 3'd0};
      req_i      = 4'b1010;
      wait_grant("rst_first_grant", ok);
      check("rst_first_grant", 32'(grant_o), 32'b0010);
      repeat (2) @(negedge clk);
      check("rst_busy_in_wait", 32'(busy_o), 1);
      check("rst_enable_low_in_wait", 32'(sr_enable_o), 0);
      reset = 1'b1;
      #1;
      check("rst_outputs_immediate",
            32'({grant_o, done_o, err_o, rdata_o, rdata_owner_o, busy_o, sr_enable_o, sr_d_o}), 0);
      @(negedge clk);
      reset     = 1'b0;
      drive_cyc = cyc;
      sb.push_back('{is_err:1'b0, owner:1, rdata:3'b100, lat:4});
      wait_grant("rst_regrant", ok);
      req_i = '0;
      check("rst_regrant", 32'(grant_o), 32'b0010);
      check("rst_regrant_lat", cyc - drive_cyc, 1);

      wait_idle();
      repeat (5) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sync_chan_arb.md
# sync_chan_arb

Round-robin scheduler that shares one 3-stage synchronizer shift register (enable / enable_ack / valid_o interface) among NUM_REQ requesters in the logphy. It accepts a request, launches the requester's data into the synchronizer, waits for the synchronized valid, captures the result and reports completion (or timeout) to the owning requester. It sits between logphy state machines and the single shared sync channel.

## Interface
- NUM_REQ, 4: number of requesters; at least 2.
- DATA_BIT_WIDTH, 3: synchronizer data width; must be greater than 1.
- TIMEOUT_CYCLES, 16: maximum number of cycles spent in LAUNCH plus WAIT before aborting; at least 5.
- clk  in  1  single clock.
- reset  in  1  asynchronous reset, active-high.
- req_i  in  NUM_REQ  level request per requester.
- req_data_i  in  NUM_REQ*DATA_BIT_WIDTH  flattened data; requester k occupies bits [k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH].
- grant_o  out  NUM_REQ  one-hot, 1-cycle pulse when a request is accepted.
- done_o  out  NUM_REQ  one-hot, 1-cycle pulse when synchronized data is in rdata_o.
- err_o  out  NUM_REQ  one-hot, 1-cycle pulse on timeout.
- rdata_o  out  DATA_BIT_WIDTH  last captured synchronizer output.
- rdata_owner_o  out  $clog2(NUM_REQ)  index of the requester that owns rdata_o.
- busy_o  out  1  high whenever the state is not IDLE.
- sr_enable_o  out  1  drives the synchronizer enable.
- sr_d_o  out  DATA_BIT_WIDTH  drives the synchronizer d_i.
- sr_enable_ack_i  in  1  synchronizer enable_ack.
- sr_valid_i  in  1  synchronizer valid_o.
- sr_q_i  in  DATA_BIT_WIDTH  synchronizer q_o.

## Operation
- **Outputs:** all outputs are registered.
- **Reset (asynchronous):**
  - Every output goes to 0 immediately.
  - State goes to IDLE, the round-robin pointer to 0, and the timeout counter to 0.
  - Reset is allowed mid-transfer. The synchronizer shares the same reset, so its pipeline flushes too; no done_o or err_o is issued for the aborted transfer.
- **States:** IDLE, LAUNCH, WAIT, DRAIN.
- **IDLE:**
  - If req_i is nonzero, select a winner by round-robin.
  - Latch the winner's data into sr_d_o and its index as the owner.
  - Pulse grant_o[winner], clear the timeout counter, go to LAUNCH.
- **Round-robin:**
  - Search starts at the pointer and wraps modulo NUM_REQ.
  - On a grant to k, the pointer becomes (k+1) mod NUM_REQ.
- **LAUNCH:**
  - Hold sr_enable_o at 1.
  - On sr_enable_ack_i=1, drive sr_enable_o to 0 from the next cycle and go to WAIT.
- **WAIT:** on the first cycle with sr_valid_i=1:
  - Capture sr_q_i into rdata_o and the owner into rdata_owner_o.
  - Pulse done_o[owner] in the next cycle, go to DRAIN.
- **DRAIN:** stay until sr_valid_i=0, then go to IDLE. This keeps a multi-cycle valid from completing the transfer twice.
- **Timeout:**
  - The counter increments every cycle in LAUNCH or WAIT.
  - When TIMEOUT_CYCLES cycles have elapsed without completion: pulse err_o[owner], force sr_enable_o to 0, go to DRAIN.
  - rdata_o is not updated on timeout.
- **Requester rules:**
  - Hold req_i and data stable until grant_o.
  - req_i is ignored outside IDLE; dropping it after grant does not abort the transfer.
  - A request held high after done_o is re-arbitrated normally.

## Timing
- **Nominal sequence** (req_i sampled in IDLE at cycle 0):
  - grant_o and sr_enable_o high in cycle 1.
  - sr_enable_ack_i high in cycle 2; sr_enable_o still high in cycle 2, low from cycle 3.
  - sr_valid_i high in cycles 4–5.
  - done_o and rdata_o valid in cycle 5; rdata_o holds until the next completion.
  - DRAIN sees sr_valid_i low in cycle 6; IDLE in cycle 7; the next grant is possible in cycle 8.
- **Latency:** grant to done_o is 4 cycles.
- **Throughput:** one transfer per 7 cycles when requests are back-to-back.
- **Simultaneous events:**
  - If sr_valid_i and timeout occur in the same cycle, completion wins.
  - sr_valid_i seen in IDLE or LAUNCH is ignored.
  - done_o and err_o are never both pulsed for one transfer.
- **Counter width:** $clog2(TIMEOUT_CYCLES+1) bits; it saturates and never wraps.

## Structure
- **Package sync_arb_pkg:**
  - typedef enum sync_arb_state_t {IDLE, LAUNCH, WAIT, DRAIN}.
  - Localparam SYNC_STAGES=3.
  - Localparam MIN_TIMEOUT=5.
- **Sub-module rr_arbiter:**
  - Parameter NUM_REQ.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant and an encoded index.
  - Combinational.
- **Top level:** holds the FSM, data/owner latches, timeout counter and pointer register.
- **Elaboration check:** an $error for NUM_REQ<2, DATA_BIT_WIDTH<=1 or TIMEOUT_CYCLES<MIN_TIMEOUT.

## Test plan
- **Single request:** req_i=4'b0010, data 3'b101 with a real synchronizer attached → grant_o=4'b0010 at cycle 1, done_o=4'b0010 at cycle 5, rdata_o=3'b101, rdata_owner_o=1.
- **All requesting:** req_i=4'b1111 held continuously after reset → grants in order 0,1,2,3,0, grants spaced 7 cycles apart.
- **Pointer wrap:** grant to 3, then req_i=4'b1001 → next grant goes to 0.
- **Stuck synchronizer:** sr_enable_ack_i tied to 0, TIMEOUT_CYCLES=16 → err_o[owner] pulses 16 cycles after grant, no done_o, sr_enable_o low, rdata_o unchanged.
- **Reset in WAIT:** assert reset while in WAIT → all outputs 0 immediately; after release, the pending req_i is regranted starting from pointer 0.
- **Valid and timeout together:** sr_valid_i asserted in the same cycle the timeout expires → done_o only, no err_o; a 3-cycle sr_valid_i pulse produces exactly one done_o.
